aes_key_schedule: RTL

- Parametrised successor to the AES-128 key expansion: supports AES-128/192/256 key lengths, selected per operation.
- Generates the full expanded schedule one 32-bit word per cycle into internal storage (start/busy/ready handshake).
- Serves any round key by index (forward or reverse order) to the cipher/inverse-cipher datapath.
- Sits between the key-load interface and the round datapath; replaces per-round on-the-fly expansion.

---
 rtl/aes_key_schedule.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key schedule: expands one word per cycle into banked storage and serves round keys by index.
// Optional storage wipe is compiled in with KEYSCHED_ZEROIZE_EN.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256,
    parameter bit REG_OUT      = 1'b1
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         ready,
    output logic         err,
    output logic [3:0]   nr,
    input  logic [3:0]   rd_round,
    output logic [127:0] rk,
    input  logic         zeroize
);
    localparam int NR_MAX = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
    localparam int ROWS   = NR_MAX + 1;
    localparam int DEPTH  = 4 * ROWS;

`ifdef KEYSCHED_ZEROIZE_EN
    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DONE, WIPE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
`endif

    state_t         state_reg, state_next;
    logic           err_reg, err_next;
    logic [5:0]     i_reg;
    logic [2:0]     j_reg;
    logic [7:0]     rcon_reg;
    logic [3:0]     nr_reg;
    logic [255:0]   key_reg;
    logic [1:0]     key_len_reg;
    logic [31:0]    win_reg [8];
    logic [31:0]    key_w [8];
    logic [31:0]    rd_word [4];
    logic [31:0]    rk_word [4];
    logic [5:0]     rd_idx [4];
    logic [2:0]     nkm1;
    logic           legal, mem_we, rk_ok;
    logic [3:0]     rd_row;
    logic [31:0]    w_prev, w_old, sub_in, sub_out, temp, w_new, mem_wdata;
    logic [127:0]   rk_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = x;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    assign legal = (key_len == 2'b00) || (key_len == 2'b01 && MAX_KEY_BITS >= 192)
                || (key_len == 2'b10 && MAX_KEY_BITS >= 256);
    assign nkm1  = (key_len_reg == 2'b01) ? 3'd5 : (key_len_reg == 2'b10) ? 3'd7 : 3'd3;

    // win_reg[0] is w[i-1]; win_reg[Nk-1] is w[i-Nk]
    assign w_prev  = win_reg[0];
    assign w_old   = win_reg[nkm1];
    assign sub_in  = (j_reg == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    assign temp    = (j_reg == 3'd0) ? (sub_out ^ {rcon_reg, 24'h0}) :
                     (nkm1 == 3'd7 && j_reg == 3'd4) ? sub_out : w_prev;
    assign w_new   = w_old ^ temp;

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    if (legal) state_next = LOAD;
                    else       err_next   = 1'b1;
                end
            end
            LOAD:   state_next = EXPAND;
            EXPAND: if (i_reg == {nr_reg, 2'b11}) state_next = DONE;
`ifdef KEYSCHED_ZEROIZE_EN
            WIPE:   if (i_reg == 6'(DEPTH - 1)) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
`ifdef KEYSCHED_ZEROIZE_EN
        if (zeroize) begin
            state_next = WIPE;
            err_next   = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_reg <= IDLE;
            err_reg   <= 1'b0;
            i_reg     <= '0;
            nr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (state_next == LOAD) begin
                key_reg     <= key;
                key_len_reg <= key_len;
            end
            case (state_reg)
                LOAD: begin
                    nr_reg   <= nr_of(key_len_reg);
                    i_reg    <= 6'(nkm1) + 6'd1;
                    j_reg    <= 3'd0;
                    rcon_reg <= 8'h01;
                    for (int k = 0; k < 8; k++) win_reg[k] <= key_w[nkm1 - 3'(k)];
                end
                EXPAND: begin
                    i_reg <= i_reg + 6'd1;
                    j_reg <= (j_reg == nkm1) ? 3'd0 : j_reg + 3'd1;
                    if (j_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
                    win_reg[0] <= w_new;
                    for (int k = 1; k < 8; k++) win_reg[k] <= win_reg[k-1];
                end
`ifdef KEYSCHED_ZEROIZE_EN
                WIPE: begin
                    i_reg   <= i_reg + 6'd1;
                    nr_reg  <= '0;
                    key_reg <= '0;
                end
`endif
                default: ;
            endcase
`ifdef KEYSCHED_ZEROIZE_EN
            if (zeroize && state_reg != WIPE) begin
                i_reg  <= '0;
                nr_reg <= '0;
            end
`endif
        end
    end

`ifdef KEYSCHED_ZEROIZE_EN
    assign mem_we = (state_reg == EXPAND) || (state_reg == WIPE);
    assign busy   = (state_reg == LOAD) || (state_reg == EXPAND) || (state_reg == WIPE);
`else
    logic zeroize_unused;
    assign zeroize_unused = zeroize;
    assign mem_we = (state_reg == EXPAND);
    assign busy   = (state_reg == LOAD) || (state_reg == EXPAND);
`endif
    assign mem_wdata = (state_reg == EXPAND) ? w_new : '0;
    assign ready     = (state_reg == DONE);
    assign err       = err_reg;
    assign nr        = nr_reg;
    assign rd_row    = (rd_round > 4'(NR_MAX)) ? 4'd0 : rd_round;
    assign rk_ok     = (state_reg == DONE) && (rd_round <= nr_reg);

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_key_w
        assign key_w[gi] = key_reg[255 - 32*gi -: 32];
    end

    // Word w[i] lives in bank i%4, row i/4, so a whole round key is one row across the banks.
    // Key words (i < Nk) are served straight from the captured key.
    for (gi = 0; gi < 4; gi++) begin : g_bank
        logic [31:0] mem [ROWS];
        always_ff @(posedge CLK) begin
            if (mem_we && i_reg[1:0] == 2'(gi)) mem[i_reg[5:2]] <= mem_wdata;
        end
        assign rd_word[gi] = mem[rd_row];
        assign rd_idx[gi]  = {rd_round, 2'b00} + 6'(gi);
        assign rk_word[gi] = (rd_idx[gi] <= 6'(nkm1)) ? key_w[rd_idx[gi][2:0]] : rd_word[gi];
    end

    assign rk_next = rk_ok ? {rk_word[0], rk_word[1], rk_word[2], rk_word[3]} : '0;

    if (REG_OUT) begin : g_rk_reg
        logic [127:0] rk_reg;
        always_ff @(posedge CLK) begin
            if (!rst) rk_reg <= '0;
            else      rk_reg <= rk_next;
        end
        assign rk = rk_reg;
    end else begin : g_rk_comb
        assign rk = rk_next;
    end
endmodule
